// File: rtl/pf_ddr4_dm_lane_dly_ctrl.sv
// TX delay-line controller for one DDR4 DM lane IOD: walks the line to an absolute tap one MOVE at a time.
// Optional DM_DLY_CTRL_MOVE_CNT_EN adds a saturating MOVE_CNT[15:0] pulse counter.
module pf_ddr4_dm_lane_dly_ctrl #(
   parameter int unsigned TAP_W      = 8,
   parameter int unsigned MAX_TAP    = 127,
   parameter int unsigned INIT_TAP   = 1,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic             FAB_CLK,
   input  logic             TX_SYNC_RST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [TAP_W-1:0] REQ_TAP,
   input  logic             REQ_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             DELAY_LINE_LOAD,
   input  logic             DELAY_LINE_OUT_OF_RANGE,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             DONE,
   output logic             DONE_ERR,
`ifdef DM_DLY_CTRL_MOVE_CNT_EN
   output logic [15:0]      MOVE_CNT,
`endif
   output logic             ERR
);

   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_SETTLE} state_t;

   state_t           state_q, state_d;
   logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
   logic [TAP_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             done_err_q, done_err_d;
   logic             err_q, err_d;
   logic             oor_q, oor_d;
   logic             op_load_q, op_load_d;
   logic             oor_seen;

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         state_q    <= S_IDLE;
         cur_tap_q  <= TAP_W'(INIT_TAP);
         target_q   <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
         err_q      <= 1'b0;
         oor_q      <= 1'b0;
         op_load_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_tap_q  <= cur_tap_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         done_q     <= done_d;
         done_err_q <= done_err_d;
         err_q      <= err_d;
         oor_q      <= oor_d;
         op_load_q  <= op_load_d;
      end
   end

   // CUR_TAP moves on the edge that enters STEP/LOAD, so it is already updated while the pulse is high.
   always_comb begin
      state_d    = state_q;
      cur_tap_d  = cur_tap_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      done_d     = 1'b0;
      done_err_d = 1'b0;
      err_d      = err_q;
      oor_d      = oor_q;
      op_load_d  = op_load_q;
      oor_seen   = oor_q | DELAY_LINE_OUT_OF_RANGE;
      case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               if (REQ_LOAD) begin
                  op_load_d = 1'b1;
                  cur_tap_d = TAP_W'(INIT_TAP);
                  state_d   = S_LOAD;
               end else if (REQ_TAP > TAP_W'(MAX_TAP)) begin
                  done_d     = 1'b1;
                  done_err_d = 1'b1;
                  err_d      = 1'b1;
               end else if (REQ_TAP == cur_tap_q) begin
                  done_d = 1'b1;
               end else begin
                  op_load_d = 1'b0;
                  target_d  = REQ_TAP;
                  dir_d     = (REQ_TAP > cur_tap_q);
                  cur_tap_d = (REQ_TAP > cur_tap_q) ? cur_tap_q + TAP_W'(1) : cur_tap_q - TAP_W'(1);
                  state_d   = S_STEP;
               end
            end
         end
         S_LOAD, S_STEP: begin
            cnt_d   = '0;
            oor_d   = 1'b0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            oor_d = oor_seen;
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               if (oor_seen) begin
                  done_d     = 1'b1;
                  done_err_d = 1'b1;
                  err_d      = 1'b1;
                  state_d    = S_IDLE;
               end else if (op_load_q || (cur_tap_q == target_q)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cur_tap_d = dir_q ? cur_tap_q + TAP_W'(1) : cur_tap_q - TAP_W'(1);
                  state_d   = S_STEP;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign REQ_READY            = (state_q == S_IDLE);
   assign DELAY_LINE_MOVE      = (state_q == S_STEP);
   assign DELAY_LINE_LOAD      = (state_q == S_LOAD);
   assign DELAY_LINE_DIRECTION = dir_q;
   assign CUR_TAP              = cur_tap_q;
   assign DONE                 = done_q;
   assign DONE_ERR             = done_err_q;
   assign ERR                  = err_q;

`ifdef DM_DLY_CTRL_MOVE_CNT_EN
   logic [15:0] move_cnt_q;

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST)
         move_cnt_q <= '0;
      else if (DELAY_LINE_MOVE && (move_cnt_q != '1))
         move_cnt_q <= move_cnt_q + 16'd1;
   end

   assign MOVE_CNT = move_cnt_q;
`endif

endmodule
